// File: rtl/lbp_param.sv
// Streaming 3x3 local binary pattern over a raster frame read from a combinational
// image memory; two line buffers plus a sliding window, valid/ready output side.
module lbp_param #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [PIX_W-1:0]  gray_data,
  input  logic              mode,
  input  logic [PIX_W-1:0]  thr,
  output logic              lbp_valid,
  input  logic              lbp_ready,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] FIRST_EMIT = ADDR_W'(IMG_W + 1);
  localparam logic [XW-1:0]     X_LAST     = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST     = YW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_reg, state_next;

  logic              mode_reg;
  logic [PIX_W-1:0]  thr_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [XW-1:0]     rd_x_reg;
  logic              s1_valid_reg, s1_emit_reg;
  logic [XW-1:0]     s1_x_reg;
  logic [PIX_W-1:0]  s1_pix_reg;
  logic              out_valid_reg, all_loaded_reg;
  logic [ADDR_W-1:0] out_addr_reg, out_idx_reg;
  logic [7:0]        out_data_reg;
  logic [XW-1:0]     out_x_reg;
  logic [YW-1:0]     out_y_reg;

  logic [PIX_W-1:0]  lb0_mem [IMG_W];
  logic [PIX_W-1:0]  lb1_mem [IMG_W];
  logic [PIX_W-1:0]  lb0_q_reg, lb1_q_reg;
  logic [PIX_W-1:0]  win_t_reg [2];
  logic [PIX_W-1:0]  win_m_reg [2];
  logic [PIX_W-1:0]  win_b_reg [2];

  logic              start, out_free, s1_fire, rd_fire, tail_load, out_load, border;
  logic [PIX_W:0]    cmp_base;
  logic [PIX_W-1:0]  nbr [8];
  logic [7:0]        lbp_code;

  // Stage 1 advances only when the output register can take its result, so a
  // stalled consumer back-pressures all the way to the read strobe.
  assign start     = (state_reg == IDLE) && gray_ready;
  assign out_free  = !out_valid_reg || lbp_ready;
  assign s1_fire   = s1_valid_reg && out_free;
  assign rd_fire   = (state_reg == RUN) && (!s1_valid_reg || s1_fire);
  assign tail_load = (state_reg == DRAIN) && !s1_valid_reg && out_free && !all_loaded_reg;
  assign out_load  = (s1_fire && s1_emit_reg) || tail_load;
  assign border    = (out_x_reg == '0) || (out_x_reg == X_LAST) ||
                     (out_y_reg == '0) || (out_y_reg == Y_LAST);

  assign gray_req  = rd_fire;
  assign gray_addr = rd_addr_reg;
  assign lbp_valid = out_valid_reg;
  assign lbp_addr  = out_addr_reg;
  assign lbp_data  = out_data_reg;

  // Window columns 0/1 hold x-2/x-1; the incoming column (x) comes from stage 1.
  assign nbr[0] = win_t_reg[0];
  assign nbr[1] = win_t_reg[1];
  assign nbr[2] = lb0_q_reg;
  assign nbr[3] = win_m_reg[0];
  assign nbr[4] = lb1_q_reg;
  assign nbr[5] = win_b_reg[0];
  assign nbr[6] = win_b_reg[1];
  assign nbr[7] = s1_pix_reg;

  assign cmp_base = {1'b0, win_m_reg[1]} + (mode_reg ? {1'b0, thr_reg} : '0);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      assign lbp_code[gi] = ({1'b0, nbr[gi]} >= cmp_base);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    finish     = 1'b0;
    case (state_reg)
      IDLE:    if (gray_ready) state_next = RUN;
      RUN:     if (rd_fire && rd_addr_reg == LAST_ADDR) state_next = DRAIN;
      DRAIN:   if (out_valid_reg && lbp_ready && out_addr_reg == LAST_ADDR) state_next = DONE;
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      mode_reg       <= 1'b0;
      thr_reg        <= '0;
      rd_addr_reg    <= '0;
      rd_x_reg       <= '0;
      s1_valid_reg   <= 1'b0;
      s1_emit_reg    <= 1'b0;
      s1_x_reg       <= '0;
      s1_pix_reg     <= '0;
      out_valid_reg  <= 1'b0;
      out_addr_reg   <= '0;
      out_data_reg   <= '0;
      out_idx_reg    <= '0;
      out_x_reg      <= '0;
      out_y_reg      <= '0;
      all_loaded_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        mode_reg       <= mode;
        thr_reg        <= thr;
        rd_addr_reg    <= '0;
        rd_x_reg       <= '0;
        s1_valid_reg   <= 1'b0;
        out_valid_reg  <= 1'b0;
        out_idx_reg    <= '0;
        out_x_reg      <= '0;
        out_y_reg      <= '0;
        all_loaded_reg <= 1'b0;
      end else begin
        if (rd_fire) begin
          rd_addr_reg  <= rd_addr_reg + ADDR_W'(1);
          rd_x_reg     <= (rd_x_reg == X_LAST) ? '0 : rd_x_reg + XW'(1);
          s1_valid_reg <= 1'b1;
          s1_emit_reg  <= (rd_addr_reg >= FIRST_EMIT);
          s1_x_reg     <= rd_x_reg;
          s1_pix_reg   <= gray_data;
        end else if (s1_fire) begin
          s1_valid_reg <= 1'b0;
        end
        if (out_load) begin
          out_valid_reg  <= 1'b1;
          out_addr_reg   <= out_idx_reg;
          out_data_reg   <= border ? 8'h00 : lbp_code;
          out_idx_reg    <= out_idx_reg + ADDR_W'(1);
          all_loaded_reg <= (out_idx_reg == LAST_ADDR);
          if (out_x_reg == X_LAST) begin
            out_x_reg <= '0;
            out_y_reg <= out_y_reg + YW'(1);
          end else begin
            out_x_reg <= out_x_reg + XW'(1);
          end
        end else if (lbp_ready) begin
          out_valid_reg <= 1'b0;
        end
      end
    end
  end

  // Line buffers and window carry no reset; border outputs never use stale data.
  always_ff @(posedge clk) begin
    if (rd_fire) begin
      lb0_q_reg <= lb0_mem[rd_x_reg];
      lb1_q_reg <= lb1_mem[rd_x_reg];
    end
    if (s1_fire) begin
      lb0_mem[s1_x_reg] <= lb1_q_reg;
      lb1_mem[s1_x_reg] <= s1_pix_reg;
      win_t_reg[0]      <= win_t_reg[1];
      win_t_reg[1]      <= lb0_q_reg;
      win_m_reg[0]      <= win_m_reg[1];
      win_m_reg[1]      <= lb1_q_reg;
      win_b_reg[0]      <= win_b_reg[1];
      win_b_reg[1]      <= s1_pix_reg;
    end
  end

endmodule
